// File: rtl/ir_fetch_queue.sv
// Instruction register + prefetch queue: assembles 1- or 2-word instructions and
// buffers them for the decoder. Two-word assembly is enabled by `define IR_Q_OPERAND_EN.
module ir_fetch_queue #(
  parameter int              DATA_W       = 8,
  parameter int              OP_W         = 4,
  parameter int              RA1_W        = 1,
  parameter int              RA2_W        = 3,
  parameter int              DEPTH        = 4,
  parameter logic [OP_W-1:0] OPERAND_BASE = 4'hC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              dec_ready,
  output logic [OP_W-1:0]   Op_code,
  output logic [RA1_W-1:0]  reg_add1,
  output logic [RA2_W-1:0]  reg_add2,
  output logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] to_PC,
  output logic              has_operand
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LAST = ptr_t'(DEPTH - 1);
  localparam cnt_t FULL = cnt_t'(DEPTH);

  ptr_t rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t count_q, count_d;
  logic [DATA_W-1:0] word_mem_q [DEPTH];

  logic              in_fire, pop, push;
  logic [DATA_W-1:0] push_word;
  logic [DATA_W-1:0] head_word;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // No bypass: a full queue refuses words even when the head pops this cycle.
  assign in_ready   = (count_q != FULL);
  assign inst_valid = (count_q != '0);
  assign in_fire    = in_valid && in_ready && !flush;
  assign pop        = inst_valid && dec_ready && !flush;

`ifdef IR_Q_OPERAND_EN
  typedef enum logic {S_OP, S_ARG} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] push_opnd;
  logic              push_has;
  logic [DATA_W-1:0] opnd_mem_q [DEPTH];
  logic [DEPTH-1:0]  has_mem_q;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    push      = 1'b0;
    push_word = in;
    push_opnd = '0;
    push_has  = 1'b0;
    if (flush) begin
      state_d = S_OP;
      pend_d  = '0;
    end else if (in_fire) begin
      case (state_q)
        S_OP: begin
          if (in[DATA_W-1 -: OP_W] >= OPERAND_BASE) begin
            pend_d  = in;
            state_d = S_ARG;
          end else begin
            push = 1'b1;
          end
        end
        S_ARG: begin
          push      = 1'b1;
          push_word = pend_q;
          push_opnd = in;
          push_has  = 1'b1;
          state_d   = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OP;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      opnd_mem_q[wr_ptr_q] <= push_opnd;
      has_mem_q[wr_ptr_q]  <= push_has;
    end
  end

  assign operand     = inst_valid ? opnd_mem_q[rd_ptr_q] : '0;
  assign has_operand = inst_valid && has_mem_q[rd_ptr_q];
`else
  assign push        = in_fire;
  assign push_word   = in;
  assign operand     = '0;
  assign has_operand = 1'b0;
`endif

  assign to_PC = operand;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) word_mem_q[wr_ptr_q] <= push_word;
  end

  assign head_word = inst_valid ? word_mem_q[rd_ptr_q] : '0;
  assign Op_code   = head_word[DATA_W-1 -: OP_W];
  assign reg_add1  = head_word[RA2_W +: RA1_W];
  assign reg_add2  = head_word[RA2_W-1:0];

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Randomized + directed bench for ir_fetch_queue against a queue-based reference model.
module tb_ir_fetch_queue;
  localparam int DEPTH = 4;
`ifdef IR_Q_OPERAND_EN
  localparam bit OPER_EN = 1'b1;
`else
  localparam bit OPER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, flush, dec_ready;
  logic [7:0] in_w;
  logic       in_ready, inst_valid, has_operand;
  logic [3:0] Op_code;
  logic [0:0] reg_add1;
  logic [2:0] reg_add2;
  logic [7:0] operand, to_PC;

  ir_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in(in_w), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .inst_valid(inst_valid), .dec_ready(dec_ready),
    .Op_code(Op_code), .reg_add1(reg_add1), .reg_add2(reg_add2),
    .operand(operand), .to_PC(to_PC), .has_operand(has_operand)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic [7:0] o;
    bit         h;
  } ent_t;

  ent_t       q[$];
  bit         pend;
  logic [7:0] pend_w;
  int         checks = 0;
  int         fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    ent_t e;
    e = '{w: 8'h00, o: 8'h00, h: 1'b0};
    if (q.size() > 0) e = q[0];
    chk("inst_valid", inst_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() != DEPTH);
    chk("op_code", Op_code, e.w[7:4]);
    chk("reg_add1", reg_add1, e.w[3]);
    chk("reg_add2", reg_add2, e.w[2:0]);
    chk("operand", operand, e.o);
    chk("to_pc", to_PC, e.o);
    chk("has_operand", has_operand, e.h);
  endtask

  task automatic model_update();
    ent_t e;
    bit   do_pop, do_push;
    do_push = 1'b0;
    e = '{w: 8'h00, o: 8'h00, h: 1'b0};
    if (rst || flush) begin
      q.delete();
      pend = 1'b0;
    end else begin
      do_pop = (q.size() > 0) && dec_ready;
      if (in_valid && q.size() != DEPTH) begin
        if (OPER_EN && pend) begin
          e = '{w: pend_w, o: in_w, h: 1'b1};
          do_push = 1'b1;
          pend = 1'b0;
        end else if (OPER_EN && in_w[7:4] >= 4'hC) begin
          pend   = 1'b1;
          pend_w = in_w;
        end else begin
          e = '{w: in_w, o: 8'h00, h: 1'b0};
          do_push = 1'b1;
        end
      end
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  // Inputs are applied at posedge+1, outputs checked at posedge+2.
  task automatic drive(input bit v, input logic [7:0] w, input bit dr, input bit fl, input bit r);
    in_valid = v; in_w = w; dec_ready = dr; flush = fl; rst = r;
    #1;
    check_model();
    model_update();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_w = '0; flush = 1'b0; dec_ready = 1'b0;
    pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_operand", operand, 8'h00);

    // One-word instruction then pop
    drive(1, 8'h25, 0, 0, 0);
    chk("d1_valid", inst_valid, 1'b1);
    chk("d1_op", Op_code, 4'h2);
    chk("d1_ra2", reg_add2, 3'h5);
    drive(0, 8'h00, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 0);

    // Opcode, stalled operand
    drive(1, 8'hC3, 0, 0, 0);
    repeat (3) drive(0, 8'h00, 0, 0, 0);
    drive(1, 8'h40, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    repeat (3) drive(0, 8'h00, 1, 0, 0);

    // Fill to full, hold off the fifth, pop while full, then drain across wrap
    for (int i = 0; i < 5; i++) drive(1, 8'h21 + 8'(i), 0, 0, 0);
    drive(1, 8'h25, 1, 0, 0);
    drive(1, 8'h25, 0, 0, 0);
    repeat (6) drive(0, 8'h00, 1, 0, 0);

    // Flush mid-assembly
    drive(1, 8'hD0, 0, 0, 0);
    drive(1, 8'h11, 0, 1, 0);
    drive(1, 8'h12, 0, 0, 0);
    chk("flush_op", Op_code, 4'h1);
    repeat (2) drive(0, 8'h00, 1, 0, 0);

    // Simultaneous push/pop at count=2, then reset mid-assembly
    drive(1, 8'h31, 0, 0, 0);
    drive(1, 8'h32, 0, 0, 0);
    drive(1, 8'h33, 1, 0, 0);
    drive(1, 8'hC5, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 1);
    chk("rstmid_valid", inst_valid, 1'b0);
    chk("rstmid_ready", in_ready, 1'b1);
    drive(1, 8'h40, 0, 0, 0);
    repeat (2) drive(0, 8'h00, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom),
            $urandom_range(0, 9) < 5,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) < 2);
    end
    repeat (DEPTH + 2) drive(0, 8'h00, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
